// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
//   Shared types for the fetch/data memory-port arbiter.
//   - arbState_ : arbiter FSM states (idle, waiting on a fetch response,
//                 waiting on a data response)
//   - arbOwner_ : which requester the idle-state arbitration picked
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_FETCH,
    ARB_WAIT_DATA
  } arbState_;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_FETCH,
    OWNER_DATA
  } arbOwner_;

endpackage : memory_arbiter_pkg

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares the core's single memory port between instruction fetch and the
//   memory stage. One transaction is outstanding at a time. Data normally wins
//   arbitration; a saturating data-streak counter hands the port to a waiting
//   fetch after MAX_DATA_STREAK back-to-back data grants.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   fetch*                : fetch request/address in, grant/response out,
//                           fetchKill abandons pending/outstanding fetches
//   data*                 : memory-stage load/store request in, grant/response
//                           out (dataReadData is 0 for stores)
//   mem*                  : request to the memory (memRequest + fields,
//                           memReady handshake) and its response
//   stallControl          : freezes the pipeline while a data access is open
// -----------------------------------------------------------------------------
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    fetchRequest,
  input  logic [ADDR_WIDTH-1:0]   fetchAddress,
  input  logic                    fetchKill,
  output logic                    fetchGrant,
  output logic                    fetchResponseValid,
  output logic [DATA_WIDTH-1:0]   fetchData,

  input  logic                    dataRequest,
  input  logic                    dataWrite,
  input  logic [ADDR_WIDTH-1:0]   dataAddress,
  input  logic [DATA_WIDTH-1:0]   dataWriteData,
  input  logic [DATA_WIDTH/8-1:0] dataByteEnable,
  output logic                    dataGrant,
  output logic                    dataResponseValid,
  output logic [DATA_WIDTH-1:0]   dataReadData,

  output logic                    memRequest,
  output logic                    memWrite,
  output logic [ADDR_WIDTH-1:0]   memAddress,
  output logic [DATA_WIDTH-1:0]   memWriteData,
  output logic [DATA_WIDTH/8-1:0] memByteEnable,
  input  logic                    memReady,
  input  logic                    memResponseValid,
  input  logic [DATA_WIDTH-1:0]   memReadData,

  output logic                    stallControl
);

  localparam int STREAK_WIDTH = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_STREAK);

  arbState_                state_q,  state_d;
  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic                    killed_q, killed_d;
  logic                    write_q,  write_d;   // owner of WAIT_DATA is a store

  logic     fetch_eligible;
  arbOwner_ owner;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
      killed_q <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      killed_q <= killed_d;
      write_q  <= write_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner selection (only meaningful in ARB_IDLE). A killed fetch is not
  // eligible, so a redirect in the same cycle never issues the stale address.
  // Data yields only when the streak is exhausted AND a fetch is actually
  // waiting; otherwise data keeps priority.
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_eligible = fetchRequest && !fetchKill;
    owner          = OWNER_NONE;
    if (dataRequest && ((streak_q < STREAK_MAX) || !fetch_eligible)) begin
      owner = OWNER_DATA;
    end else if (fetch_eligible) begin
      owner = OWNER_FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. Everything is held at zero while reset is high so
  // the pipeline sees no grant, response or stall during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d            = state_q;
    killed_d           = killed_q;
    write_d            = write_q;

    fetchGrant         = 1'b0;
    fetchResponseValid = 1'b0;
    fetchData          = '0;
    dataGrant          = 1'b0;
    dataResponseValid  = 1'b0;
    dataReadData       = '0;
    memRequest         = 1'b0;
    memWrite           = 1'b0;
    memAddress         = '0;
    memWriteData       = '0;
    memByteEnable      = '0;
    stallControl       = 1'b0;

    if (!reset) begin
      unique case (state_q)
        ARB_IDLE: begin
          // Responses seen here belong to nothing we issued; ignore them.
          if (owner == OWNER_DATA) begin
            memRequest    = 1'b1;
            memWrite      = dataWrite;
            memAddress    = dataAddress;
            memWriteData  = dataWriteData;
            memByteEnable = dataByteEnable;
            if (memReady) begin
              dataGrant = 1'b1;
              write_d   = dataWrite;
              state_d   = ARB_WAIT_DATA;
            end
          end else if (owner == OWNER_FETCH) begin
            memRequest    = 1'b1;
            memWrite      = 1'b0;
            memAddress    = fetchAddress;
            memWriteData  = '0;
            memByteEnable = '1;
            if (memReady) begin
              fetchGrant = 1'b1;
              killed_d   = 1'b0;
              state_d    = ARB_WAIT_FETCH;
            end
          end
        end

        ARB_WAIT_FETCH: begin
          if (memResponseValid) begin
            // A kill earlier in the wait, or in this very cycle, makes the
            // instruction stale: swallow it and free the port.
            if (!killed_q && !fetchKill) begin
              fetchResponseValid = 1'b1;
              fetchData          = memReadData;
            end
            killed_d = 1'b0;
            state_d  = ARB_IDLE;
          end else if (fetchKill) begin
            killed_d = 1'b1;
          end
        end

        ARB_WAIT_DATA: begin
          if (memResponseValid) begin
            dataResponseValid = 1'b1;
            dataReadData      = write_q ? '0 : memReadData;
            state_d           = ARB_IDLE;
          end
        end

        default: state_d = ARB_IDLE;
      endcase

      stallControl = dataRequest && !dataResponseValid;
    end
  end

  // ---------------------------------------------------------------------------
  // Data streak: counts data grants taken while a fetch is waiting. It resets
  // as soon as fetch stops asking or finally gets the port.
  // ---------------------------------------------------------------------------
  always_comb begin
    streak_d = streak_q;
    if (!fetchRequest || fetchGrant) begin
      streak_d = '0;
    end else if (dataGrant && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed bench for memory_arbiter (MAX_DATA_STREAK = 2). Stimulus pushes
//   expected grants and responses into queues; a monitor pops and compares
//   whenever the DUT pulses a grant or response. Timing-specific properties
//   (cycle of response, stall window, field stability, reset gating) are
//   checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam logic [31:0] G_DATA  = 32'd1;
  localparam logic [31:0] G_FETCH = 32'd2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetchRequest = 1'b0;
  logic [AW-1:0] fetchAddress = '0;
  logic          fetchKill = 1'b0;
  logic          fetchGrant, fetchResponseValid;
  logic [DW-1:0] fetchData;
  logic          dataRequest = 1'b0;
  logic          dataWrite = 1'b0;
  logic [AW-1:0] dataAddress = '0;
  logic [DW-1:0] dataWriteData = '0;
  logic [BW-1:0] dataByteEnable = '0;
  logic          dataGrant, dataResponseValid;
  logic [DW-1:0] dataReadData;
  logic          memRequest, memWrite;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData;
  logic [BW-1:0] memByteEnable;
  logic          memReady = 1'b1;
  logic          memResponseValid = 1'b0;
  logic [DW-1:0] memReadData = '0;
  logic          stallControl;

  always #5 clock = ~clock;

  memory_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(2)
  ) dut (
    .clock(clock), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress), .fetchKill(fetchKill),
    .fetchGrant(fetchGrant), .fetchResponseValid(fetchResponseValid), .fetchData(fetchData),
    .dataRequest(dataRequest), .dataWrite(dataWrite), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
    .dataGrant(dataGrant), .dataResponseValid(dataResponseValid), .dataReadData(dataReadData),
    .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memByteEnable(memByteEnable), .memReady(memReady),
    .memResponseValid(memResponseValid), .memReadData(memReadData),
    .stallControl(stallControl)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_grant_q[$];
  logic [31:0] exp_dresp_q[$];
  logic [31:0] exp_fresp_q[$];

  int          mem_latency = 1;
  logic [31:0] mem_rdata   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Memory model: accepts at the negedge of the issue cycle, answers
  // mem_latency cycles later. It keeps counting across a DUT reset so a late
  // response can land while the arbiter is idle.
  initial begin : mem_model
    bit pend;
    int cnt;
    pend = 0;
    cnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      memResponseValid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          memResponseValid = 1'b1;
          memReadData      = mem_rdata;
          pend             = 0;
        end
      end
      @(negedge clock);
      if (memRequest && memReady) begin
        pend = 1;
        cnt  = mem_latency;
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (dataGrant) begin
        $display("[%0t] data grant addr=%h write=%0d", $time, memAddress, memWrite);
        if (exp_grant_q.size() == 0) check("unexpected_data_grant", 32'd1, 32'd0);
        else check("grant_order", G_DATA, exp_grant_q.pop_front());
      end
      if (fetchGrant) begin
        $display("[%0t] fetch grant addr=%h", $time, memAddress);
        if (exp_grant_q.size() == 0) check("unexpected_fetch_grant", 32'd1, 32'd0);
        else check("grant_order", G_FETCH, exp_grant_q.pop_front());
      end
      if (dataResponseValid) begin
        $display("[%0t] data response rdata=%h", $time, dataReadData);
        if (exp_dresp_q.size() == 0) check("unexpected_data_response", 32'd1, 32'd0);
        else check("data_response", dataReadData, exp_dresp_q.pop_front());
      end
      if (fetchResponseValid) begin
        $display("[%0t] fetch response data=%h", $time, fetchData);
        if (exp_fresp_q.size() == 0) check("unexpected_fetch_response", 32'd1, 32'd0);
        else check("fetch_response", fetchData, exp_fresp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  initial begin : stimulus
    // ---------------- Reset: requests present, everything must stay 0
    dataRequest  = 1'b1;
    fetchRequest = 1'b1;
    dataAddress  = 32'h100;
    fetchAddress = 32'h0;
    neg();
    check("rst_memRequest", memRequest, 0);
    check("rst_grants", {dataGrant, fetchGrant}, 0);
    check("rst_resp", {dataResponseValid, fetchResponseValid}, 0);
    check("rst_stall", stallControl, 0);
    check("rst_memAddress", memAddress, 0);
    tick();
    reset = 1'b0; dataRequest = 1'b0; fetchRequest = 1'b0;
    tick();

    // ---------------- Single load, 3-cycle memory
    mem_latency = 3; mem_rdata = 32'hDEADBEEF; memReady = 1'b1;
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h100;
    exp_grant_q.push_back(G_DATA);
    exp_dresp_q.push_back(32'hDEADBEEF);
    neg();
    check("load_grant_c0", dataGrant, 1);
    check("load_addr", memAddress, 32'h100);
    check("load_stall_c0", stallControl, 1);
    for (int c = 1; c <= 2; c++) begin
      tick(); neg();
      check("load_no_early_resp", dataResponseValid, 0);
      check("load_stall_wait", stallControl, 1);
      check("load_memreq_wait", memRequest, 0);
    end
    tick(); neg();
    check("load_resp_c3", dataResponseValid, 1);
    check("load_stall_c3", stallControl, 0);
    tick();
    dataRequest = 1'b0;
    tick();

    // ---------------- Contention, 1-cycle memory: D D F D D F
    mem_latency = 1; mem_rdata = 32'h11110000;
    dataRequest = 1'b1; dataAddress = 32'h300;
    fetchRequest = 1'b1; fetchAddress = 32'h0;
    exp_grant_q.push_back(G_DATA);  exp_grant_q.push_back(G_DATA);
    exp_grant_q.push_back(G_FETCH); exp_grant_q.push_back(G_DATA);
    exp_grant_q.push_back(G_DATA);  exp_grant_q.push_back(G_FETCH);
    repeat (4) exp_dresp_q.push_back(32'h11110000);
    repeat (2) exp_fresp_q.push_back(32'h11110000);
    repeat (12) tick();
    dataRequest = 1'b0; fetchRequest = 1'b0;
    neg();
    check("contention_order_drained", exp_grant_q.size(), 0);
    tick();

    // ---------------- Kill in IDLE blocks issue
    fetchRequest = 1'b1; fetchKill = 1'b1; fetchAddress = 32'h40;
    neg();
    check("kill_idle_no_req", memRequest, 0);
    tick();
    fetchKill = 1'b0;

    // ---------------- Kill in flight
    mem_latency = 2; mem_rdata = 32'h13;
    fetchRequest = 1'b1; fetchAddress = 32'h40;
    exp_grant_q.push_back(G_FETCH);
    neg();
    check("kill_fetch_grant", fetchGrant, 1);
    tick();
    fetchKill = 1'b1; fetchRequest = 1'b0;
    neg();
    tick();
    fetchKill = 1'b0;
    neg();
    check("kill_resp_suppressed", fetchResponseValid, 0);
    check("kill_resp_arrived", memResponseValid, 1);
    tick();
    mem_latency = 1; mem_rdata = 32'h00500093;
    fetchRequest = 1'b1; fetchAddress = 32'h80;
    exp_grant_q.push_back(G_FETCH);
    exp_fresp_q.push_back(32'h00500093);
    neg();
    check("refetch_grant_idle", fetchGrant, 1);
    check("refetch_addr", memAddress, 32'h80);
    check("refetch_be", memByteEnable, 4'hF);
    check("refetch_read", memWrite, 0);
    tick();
    fetchRequest = 1'b0;
    neg();
    check("refetch_resp", fetchResponseValid, 1);
    tick();

    // ---------------- Store
    mem_latency = 1; mem_rdata = 32'hFFFFFFFF;
    dataRequest = 1'b1; dataWrite = 1'b1; dataAddress = 32'h200;
    dataWriteData = 32'hAABBCCDD; dataByteEnable = 4'b0011;
    exp_grant_q.push_back(G_DATA);
    exp_dresp_q.push_back(32'h0);
    neg();
    check("store_memWrite", memWrite, 1);
    check("store_addr", memAddress, 32'h200);
    check("store_wdata", memWriteData, 32'hAABBCCDD);
    check("store_be", memByteEnable, 4'b0011);
    tick(); neg();
    check("store_resp", dataResponseValid, 1);
    tick();
    dataRequest = 1'b0; dataWrite = 1'b0; dataWriteData = '0; dataByteEnable = '0;
    tick();

    // ---------------- Backpressure: memReady low 4 cycles
    memReady = 1'b0; mem_rdata = 32'h12345678;
    dataRequest = 1'b1; dataAddress = 32'h104;
    for (int c = 0; c < 4; c++) begin
      neg();
      check("bp_memRequest", memRequest, 1);
      check("bp_addr_stable", memAddress, 32'h104);
      check("bp_no_grant", dataGrant, 0);
      check("bp_stall", stallControl, 1);
      tick();
    end
    memReady = 1'b1;
    exp_grant_q.push_back(G_DATA);
    exp_dresp_q.push_back(32'h12345678);
    neg();
    check("bp_grant", dataGrant, 1);
    tick(); neg();
    check("bp_resp", dataResponseValid, 1);
    tick();
    dataRequest = 1'b0;
    tick();

    // ---------------- Reset mid-op
    mem_latency = 3; mem_rdata = 32'h55;
    dataRequest = 1'b1; dataAddress = 32'h108;
    exp_grant_q.push_back(G_DATA);
    neg();
    check("rmid_grant", dataGrant, 1);
    tick();
    reset = 1'b1;
    neg();
    check("rmid_memRequest", memRequest, 0);
    check("rmid_stall", stallControl, 0);
    check("rmid_resp", {dataResponseValid, fetchResponseValid}, 0);
    check("rmid_rdata", dataReadData, 0);
    tick();
    reset = 1'b0; dataRequest = 1'b0;
    neg();
    tick(); neg();
    check("rmid_late_arrived", memResponseValid, 1);
    check("rmid_late_ignored", dataResponseValid, 0);
    tick();
    repeat (3) tick();

    check("grant_queue_empty", exp_grant_q.size(), 0);
    check("dresp_queue_empty", exp_dresp_q.size(), 0);
    check("fresp_queue_empty", exp_fresp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_memory_arbiter

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the core's single memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). One transaction is outstanding at a time, and data is normally given priority. A bounded data-streak counter prevents fetch starvation. The block drives `stallControl` into the pipeline hazard unit while a data access is unfinished, and discards fetch responses that a PC redirect has made stale.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data bus width; byte enables are `DATA_WIDTH/8`
- `MAX_DATA_STREAK`, 4, consecutive data grants allowed while fetch waits; must be ≥1

Ports:
- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `fetchRequest` in 1: fetch wants a read; held with `fetchAddress` until `fetchGrant`
- `fetchAddress` in ADDR_WIDTH: instruction address
- `fetchKill` in 1: redirect flush; abandons any pending or outstanding fetch
- `fetchGrant` out 1: one-cycle pulse, fetch issue accepted by memory
- `fetchResponseValid` out 1: one-cycle pulse, `fetchData` valid
- `fetchData` out DATA_WIDTH: instruction word
- `dataRequest` in 1: memory stage access; held with all data fields until `dataResponseValid`
- `dataWrite` in 1: 1 = store, 0 = load
- `dataAddress` in ADDR_WIDTH: data address
- `dataWriteData` in DATA_WIDTH: store data
- `dataByteEnable` in DATA_WIDTH/8: store byte mask
- `dataGrant` out 1: one-cycle pulse, data issue accepted
- `dataResponseValid` out 1: one-cycle pulse, access complete
- `dataReadData` out DATA_WIDTH: load data; 0 for stores
- `memRequest` out 1: issue request to memory
- `memWrite`, `memAddress`, `memWriteData`, `memByteEnable` out: fields of the issued request
- `memReady` in 1: memory accepts the request this cycle
- `memResponseValid` in 1: memory completes the outstanding request; writes also respond
- `memReadData` in DATA_WIDTH: read data
- `stallControl` out 1: to the hazard unit; freezes all pipeline registers

## Operation
- FSM states: `ARB_IDLE`, `ARB_WAIT_FETCH`, `ARB_WAIT_DATA`.
- Owner selection in IDLE (combinational):
  - Data is selected if `dataRequest` and (`streak < MAX_DATA_STREAK` or no eligible fetch).
  - Otherwise fetch is selected if eligible.
  - Fetch is eligible when `fetchRequest` and not `fetchKill`.
- In IDLE, `memRequest` = 1 if an owner is selected, and the mem fields mux from that owner. Fetch issues are reads with all byte enables set.
- Issue is accepted when `memRequest && memReady`. The owner's grant pulses that cycle, and the FSM moves to `ARB_WAIT_DATA` or `ARB_WAIT_FETCH`. Without `memReady`, the FSM stays in IDLE and re-arbitrates next cycle.
- In a WAIT state:
  - `memRequest` = 0.
  - On `memResponseValid`, the owner's response valid pulses with `memReadData` passed through (`dataReadData` forced to 0 for stores, using the latched write flag), and the FSM returns to IDLE.
- Streak counter, width `$clog2(MAX_DATA_STREAK+1)`:
  - Increments, saturating, on a data grant while `fetchRequest` is high.
  - Clears on a fetch grant, or when `fetchRequest` is low.
- Kill handling:
  - `fetchKill` in `ARB_WAIT_FETCH` sets a `killed` flag. The matching response is consumed, `fetchResponseValid` is suppressed, and `killed` clears.
  - `fetchKill` in the same cycle as the response also suppresses it.
  - `fetchKill` in IDLE blocks a fetch issue that cycle.
- `stallControl` = `dataRequest && !dataResponseValid`, combinational.
- `memResponseValid` arriving in IDLE is ignored. This covers stale responses after reset.

## Timing
- Reset values:
  - state `ARB_IDLE`, streak 0, `killed` 0.
  - All grant, response valid, `memRequest` and `stallControl` outputs are 0 while `reset` is high.
  - Data outputs are 0.
- Minimum latency: issue in cycle N, response in N+1 at the earliest. The response is forwarded combinationally in the cycle `memResponseValid` is seen.
- There is one idle bubble between transactions: the next issue is no earlier than the cycle after the response.
- Simultaneous fetch and data requests with streak < MAX go to data. With streak = MAX they go to fetch.
- Reset mid-transaction: the FSM returns to IDLE and the outstanding response is dropped.

## Structure
- In `pack`: `typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_FETCH, ARB_WAIT_DATA} arbState_`.
- No sub-module. The streak counter, FSM and output mux stay in one file, roughly 200 lines.

## Test plan
- Single load:
  - Stimulus: `dataRequest`=1, load from 0x100, memory ready immediately and responds 3 cycles later with 0xDEADBEEF.
  - Required: `dataGrant` in cycle 0, `dataResponseValid` with 0xDEADBEEF in cycle 3, `stallControl` high in cycles 0–2.
- Contention with `MAX_DATA_STREAK`=2:
  - Stimulus: fetch and data requesting continuously, 1-cycle memory.
  - Required: grant order D, D, F, D, D, F; no fetch wait longer than 2 data transactions.
- Kill in flight:
  - Stimulus: fetch granted at 0x40, `fetchKill` in the first wait cycle, response 0x13 arrives.
  - Required: no `fetchResponseValid`, FSM back in IDLE, next fetch at 0x80 returns normally.
- Store:
  - Stimulus: store 0xAABBCCDD, byte enable 0b0011, to 0x200.
  - Required: `memWrite`=1 with matching fields; `dataResponseValid` with `dataReadData`=0.
- Backpressure:
  - Stimulus: `memReady` low for 4 cycles with data pending.
  - Required: `memRequest` held with stable fields, no grant until `memReady`, `stallControl` high throughout.
- Reset mid-op:
  - Stimulus: `reset` asserted in `ARB_WAIT_DATA`, then the late `memResponseValid` arrives in IDLE.
  - Required: no response pulses, all outputs 0 during reset.
